uart_tx_drain: RTL and testbench
================================

# uart_tx_drain

UART transmit engine that drains the transmit FIFO and serialises each byte onto the TxD line. It sits between the TX-side FIFO and the pad. It pops one word per frame using the FIFO's one-cycle `Read` strobe and registered read data. It emits start, data (LSB first), optional parity and stop bits at a rate set by a clock-divider parameter.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the FIFO data width.
- CLKS_PER_BIT, 16, Clk cycles per serial bit; minimum 4.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Fifo_Status  input  4  FIFO flags {AEmpty, AFull, Full, Empty}; only bit 0 (Empty) is used.
- Fifo_Data  input  DATA_WIDTH  FIFO read data; valid the cycle after Fifo_Read is high.
- Fifo_Read  output  1  one-cycle pop strobe to the FIFO.
- Tx_Enable  input  1  permits new frames to start; the current frame always completes.
- TxD  output  1  serial line; idle high; registered.
- Tx_Busy  output  1  high from FETCH through the end of the last stop bit.
- Tx_Done  output  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY (macro only), STOP.
- IDLE: TxD=1. When Tx_Enable=1 and Empty=0, go to FETCH.
- FETCH: Fifo_Read=1 for exactly this cycle, then go to LOAD.
- LOAD: capture Fifo_Data into the shift register, clear the bit counter, then go to START.
- START: TxD=0 for CLKS_PER_BIT cycles.
- DATA: TxD=shift[0]; shift right once every CLKS_PER_BIT cycles; DATA_WIDTH bits total.
- STOP: TxD=1 for STOP_BITS×CLKS_PER_BIT cycles; Tx_Done pulses in the last cycle; then go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state change. A bit ends when count == CLKS_PER_BIT-1.
- Empty is sampled only in IDLE. Fifo_Read is never asserted while Empty=1.
- Tx_Enable falling mid-frame: the frame finishes normally; no new fetch occurs.
- Fifo_Status/Fifo_Data changes outside FETCH/LOAD are ignored.
- Reset: state=IDLE, TxD=1, Fifo_Read=0, Tx_Busy=0, Tx_Done=0, counters=0, shift register=0. Reset during a frame aborts it; the popped word is lost and is not re-fetched.

## Timing
- Fifo_Read high in cycle N → word captured in cycle N+1 → start bit driven from cycle N+2.
- Frame length: (1 + DATA_WIDTH + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back frames: IDLE is entered for exactly one cycle after the stop bit. FETCH and LOAD follow, so TxD stays high for exactly 3 extra cycles between the stop bit end and the next start bit.
- Tx_Busy rises in the FETCH cycle and falls in the cycle after Tx_Done.
- TxD is a flop output with no combinational path from any input.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state follows DATA. TxD carries even parity (XOR of all data bits) for CLKS_PER_BIT cycles.
- UART_TX_PARITY_EN undefined: DATA goes straight to STOP. No parity logic or state encoding is generated.

## Structure
- Package uart_tx_pkg holds:
  - the state encoding constants;
  - FIFO status bit indices (EMPTY=0, FULL=1, AFULL=2, AEMPTY=3), shared with the FIFO side;
  - a function that returns the counter width from CLKS_PER_BIT and DATA_WIDTH.
- One sub-module, uart_tx_baud_cnt, holds the per-bit cycle counter. It has clear and tick outputs and is reused by the receive side.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1.
- Reset held, then released with Empty=1 for 100 cycles → TxD=1 throughout, Fifo_Read never high, Tx_Busy=0.
- One word 0xA5, no parity → a single Fifo_Read pulse. TxD shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles. Tx_Done pulses 40 cycles after the start bit begins.
- Words 0x00 then 0xFF queued → two Fifo_Read pulses 43 cycles apart, with exactly a 3-cycle extra high gap before the second start bit.
- Tx_Enable dropped during data bit 2 with a second word queued → the first frame completes, no second Fifo_Read, Tx_Busy falls.
- Reset asserted during data bit 3 → TxD=1 and Tx_Busy=0 in the same cycle. After release with Empty=0, a fresh FETCH occurs and a full frame follows.
- UART_TX_PARITY_EN defined: 0x07 → parity bit 1; 0x03 → parity bit 0; frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx_drain_pkg.sv
// uart_tx_pkg: shared state encoding, FIFO flag indices and counter sizing (PARITY state only with UART_TX_PARITY_EN)
package uart_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;
  localparam int EMPTY  = 0;
  localparam int FULL   = 1;
  localparam int AFULL  = 2;
  localparam int AEMPTY = 3;
  // One width serves both the baud counter and the bit counter
  function automatic int cnt_width(input int cpb, input int dw);
    int m;
    m = (cpb > dw) ? cpb : dw;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: FIFO-side and line-side signals of the TX drain engine
interface uart_tx_drain_if #(parameter int DATA_WIDTH = 8);
  logic [3:0]            Fifo_Status;
  logic [DATA_WIDTH-1:0] Fifo_Data;
  logic                  Fifo_Read;
  logic                  Tx_Enable;
  logic                  TxD;
  logic                  Tx_Busy;
  logic                  Tx_Done;
  modport master (input Fifo_Status, Fifo_Data, Tx_Enable, output Fifo_Read, TxD, Tx_Busy, Tx_Done);
  modport slave (output Fifo_Status, Fifo_Data, Tx_Enable, input Fifo_Read, TxD, Tx_Busy, Tx_Done);
endinterface

// File: rtl/uart_tx_baud_cnt.sv
// uart_tx_baud_cnt: per-bit cycle counter, wraps at CLKS_PER_BIT-1 and clears on request
module uart_tx_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tick
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(CLKS_PER_BIT - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops TX FIFO words and serialises them onto TxD; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS = 1
) (
  input logic Clk,
  input logic Reset,
  uart_tx_drain_if.master bus
);
  localparam int W = cnt_width(CLKS_PER_BIT, DATA_WIDTH);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [W-1:0] bit_q, bit_d, cnt;
  logic tick, clr;
  logic txd_q, txd_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  logic unused_status;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign unused_status = ^bus.Fifo_Status[3:1];
  uart_tx_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT), .W(W)) u_baud (
    .clk(Clk), .rst(Reset), .clr(clr), .cnt(cnt), .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.Tx_Enable && !bus.Fifo_Status[EMPTY]) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_START;
        shift_d = bus.Fifo_Data;
        bit_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d = ^bus.Fifo_Data;
`endif
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + W'(1);
        if (bit_q == W'(DATA_WIDTH - 1)) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP: if (tick) begin
        bit_d = bit_q + W'(1);
        if (bit_q == W'(STOP_BITS - 1)) begin
          bit_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clr = state_d != state_q;
    // Outputs are registered, so they are derived from the next state
    txd_d = (state_d == ST_START) ? 1'b0 : (state_d == ST_DATA) ? shift_d[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state_d == ST_PARITY) txd_d = par_d;
`endif
    rd_d = state_d == ST_FETCH;
    busy_d = state_d != ST_IDLE;
    done_d = state_q == ST_STOP && state_d == ST_STOP && bit_d == W'(STOP_BITS - 1) && cnt == W'(CLKS_PER_BIT - 2);
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q <= '0;
      txd_q <= 1'b1;
      rd_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      txd_q <= txd_d;
      rd_q <= rd_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  assign bus.TxD = txd_q;
  assign bus.Fifo_Read = rd_q;
  assign bus.Tx_Busy = busy_q;
  assign bus.Tx_Done = done_q;
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: self-checking bench for uart_tx_drain; parity expectations follow UART_TX_PARITY_EN
module tb_uart_tx_drain;
  import uart_tx_pkg::*;
  localparam int CPB = 4, DW = 8, SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = 1 + DW + P + SB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_drain_if #(.DATA_WIDTH(DW)) bus ();
  uart_tx_drain #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );
  logic [7:0] fmem [0:255];
  int wp = 0, rp = 0, npush = 0;
  assign bus.Fifo_Status = {3'b000, wp == rp};
  always @(posedge clk)
    if (bus.Fifo_Read) begin
      bus.Fifo_Data <= fmem[rp[7:0]];
      rp <= rp + 1;
    end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int rd_n = 0, last_rd = -100, rd_bad = 0;
  logic rd_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.Fifo_Read) begin
      rd_n <= rd_n + 1;
      last_rd <= cyc;
      if (rd_prev || bus.Fifo_Status[EMPTY]) rd_bad <= rd_bad + 1;
    end
    rd_prev <= bus.Fifo_Read;
  end
  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    fmem[wp[7:0]] = d;
    wp = wp + 1;
    npush++;
  endtask
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (P == 1 && b == DW + 1) return p;
    return 1'b1;
  endfunction
  // Waits for a start bit, then compares every cycle of the frame with the ideal waveform
  task automatic rx_frame(input string nm, input logic [7:0] d, input logic p, output int st);
    int wave, dn, by, n;
    wave = 0; dn = 0; by = 0; n = 0; st = -1;
    while (bus.TxD !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_start_seen"}, bus.TxD, 0);
    if (bus.TxD !== 1'b0) return;
    st = cyc;
    for (int i = 0; i < L * CPB; i++) begin
      if (bus.TxD !== exp_bit(d, p, i / CPB)) wave++;
      if (bus.Tx_Done !== 1'(i == L * CPB - 1)) dn++;
      if (bus.Tx_Busy !== 1'b1) by++;
      @(negedge clk);
    end
    check({nm, "_wave"}, wave, 0);
    check({nm, "_done"}, dn, 0);
    check({nm, "_busy"}, by, 0);
    check({nm, "_idle_after"}, {bus.Tx_Busy, bus.Tx_Done, bus.TxD}, 3'b001);
  endtask
  typedef struct {
    logic [7:0] data;
    logic par;
  } vec_t;
  vec_t tv [8];
  logic [7:0] exp_q [$];
  logic [7:0] d;
  int st, st1, st2, rd1, r, n, bad, k;
  initial begin
    tv[0] = '{8'hA5, 1'b0};
    tv[1] = '{8'h07, 1'b1};
    tv[2] = '{8'h03, 1'b0};
    tv[3] = '{8'h00, 1'b0};
    tv[4] = '{8'hFF, 1'b0};
    tv[5] = '{8'h80, 1'b1};
    tv[6] = '{8'h5A, 1'b0};
    tv[7] = '{8'h01, 1'b1};
    bus.Tx_Enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", bus.TxD, 1);
    check("rst_busy", bus.Tx_Busy, 0);
    check("rst_read", bus.Fifo_Read, 0);
    check("rst_done", bus.Tx_Done, 0);
    rst = 1'b0;
    bus.Tx_Enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.TxD !== 1'b1 || bus.Fifo_Read !== 1'b0 || bus.Tx_Busy !== 1'b0) bad++;
    end
    check("empty_idle", bad, 0);
    for (int i = 0; i < 8; i++) begin
      r = rd_n;
      push(tv[i].data);
      rx_frame($sformatf("vec%0d", i), tv[i].data, tv[i].par, st);
      check($sformatf("vec%0d_latency", i), st, last_rd + 2);
      check($sformatf("vec%0d_reads", i), rd_n, r + 1);
    end
    push(8'h00);
    push(8'hFF);
    rx_frame("b2b0", 8'h00, 1'b0, st1);
    rd1 = last_rd;
    rx_frame("b2b1", 8'hFF, 1'b0, st2);
    check("b2b_read_gap", last_rd - rd1, L * CPB + 3);
    check("b2b_extra_high", st2 - (st1 + L * CPB), 3);
    push(8'h3C);
    push(8'hC3);
    fork
      rx_frame("drop", 8'h3C, ^8'h3C, st);
      begin
        n = 0;
        while (bus.TxD !== 1'b0 && n < 300) begin
          @(negedge clk);
          n++;
        end
        repeat (3 * CPB + 1) @(negedge clk);
        bus.Tx_Enable = 1'b0;
      end
    join
    r = rd_n;
    repeat (60) @(negedge clk);
    check("drop_no_read", rd_n, r);
    check("drop_busy", bus.Tx_Busy, 0);
    check("drop_pending", wp - rp, 1);
    bus.Tx_Enable = 1'b1;
    rx_frame("resume", 8'hC3, ^8'hC3, st);
    push(8'h96);
    push(8'h69);
    n = 0;
    while (bus.TxD !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_start_seen", bus.TxD, 0);
    repeat (4 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_txd", bus.TxD, 1);
    check("rstmid_busy", bus.Tx_Busy, 0);
    @(negedge clk);
    rst = 1'b0;
    r = rd_n;
    rx_frame("after_rst", 8'h69, ^8'h69, st);
    check("after_rst_fetch", rd_n, r + 1);
    check("after_rst_latency", st, last_rd + 2);
    for (int b = 0; b < 4; b++) begin
      bus.Tx_Enable = 1'b0;
      r = rd_n;
      k = $urandom_range(1, 4);
      repeat ($urandom_range(2, 15)) @(negedge clk);
      for (int j = 0; j < k; j++) begin
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        push(d);
      end
      repeat ($urandom_range(2, 10)) @(negedge clk);
      check("rnd_hold", rd_n, r);
      bus.Tx_Enable = 1'b1;
      for (int j = 0; j < k; j++) begin
        d = exp_q.pop_front();
        rx_frame($sformatf("rnd%0d_%0d", b, j), d, ^d, st);
      end
    end
    check("read_total", rd_n, npush);
    check("read_protocol", rd_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got running expected finished");
    $fatal(1);
  end
endmodule
